bcd_8421n_seq: RTL and testbench

- Sequencer that converts a packed multi-digit BCD word into the 8,4,-2,-1 weighted code.
- Uses one shared single-digit converter, time-multiplexed over the digits, least-significant digit first.
- Sits between a BCD producer and a code consumer, with valid/ready handshakes on both sides.
- Flags each digit above 9 in a per-digit error mask.

---
 rtl/bcd_8421n_seq.sv | 104 ++++++++++
 tb/tb_bcd_8421n_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_8421n_seq.sv
// Time-multiplexed BCD to 8,4,-2,-1 code converter with valid/ready handshakes.
// One shared digit converter walks the latched word least-significant digit first.
module bcd_8421n_seq #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_code,
  output logic [DIGITS-1:0]     err_mask,
  output logic                  out_err,
  output logic                  busy
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]          state;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] bcd_q;

  logic [3:0] digit;
  logic [3:0] code;
  logic       digit_bad;

  // Shared single-digit converter, fed by the digit the index points at.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    code      = 4'b0000;
    digit_bad = 1'b0;
    digit     = bcd_q[int'(idx)*4 +: 4];
    case (digit)
      4'd0:    code = 4'b0000;
      4'd1:    code = 4'b0111;
      4'd2:    code = 4'b0110;
      4'd3:    code = 4'b0101;
      4'd4:    code = 4'b0100;
      4'd5:    code = 4'b1011;
      4'd6:    code = 4'b1010;
      4'd7:    code = 4'b1001;
      4'd8:    code = 4'b1000;
      4'd9:    code = 4'b1111;
      default: digit_bad = 1'b1;
    endcase
  end

  // NOTE: the latched input word carries no reset; it is only read after an accept reloads it.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid && !rst) begin
      bcd_q <= in_bcd;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      out_code <= '0;
      err_mask <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            out_code <= '0;
            err_mask <= '0;
            idx      <= '0;
            state    <= CONV;
          end
        end
        CONV: begin
          out_code[int'(idx)*4 +: 4] <= code;
          err_mask[idx]              <= digit_bad;
          if (idx == LAST_IDX) begin
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status decodes come from registered state; rst only masks them while asserted.
  assign in_ready  = !rst && (state == IDLE);
  assign busy      = !rst && (state == CONV);
  assign out_valid = !rst && (state == DONE);
  assign out_err   = !rst && (|err_mask);

endmodule

// File: tb/tb_bcd_8421n_seq.sv
// Self-checking bench for bcd_8421n_seq: directed words from the test plan plus
// randomized words, compared against a weight-search reference model.
module tb_bcd_8421n_seq;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_bcd;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_code;
  logic [DIGITS-1:0] err_mask;
  logic          out_err;
  logic          busy;

  int total = 0;
  int bad   = 0;

  bcd_8421n_seq #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_bcd   (in_bcd),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_code (out_code),
    .err_mask (err_mask),
    .out_err  (out_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: digit d maps to the unique 4-bit pattern whose weighted sum
  // 8*b3 + 4*b2 - 2*b1 - b0 equals d; digits above 9 give 0 and an error bit.
  function automatic logic [W-1:0] ref_code(input logic [W-1:0] w, output logic [DIGITS-1:0] m);
    logic [W-1:0] r;
    r = '0;
    m = '0;
    for (int k = 0; k < DIGITS; k++) begin
      int d;
      d = int'(w[4*k +: 4]);
      if (d > 9) begin
        m[k] = 1'b1;
      end else begin
        for (int c = 15; c >= 0; c--) begin
          logic [3:0] p;
          p = 4'(c);
          if (8*int'(p[3]) + 4*int'(p[2]) - 2*int'(p[1]) - int'(p[0]) == d)
            r[4*k +: 4] = p;
        end
      end
    end
    return r;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
  endtask

  // Accept one word, check CONV timing, results, backpressure hold, then release.
  task automatic run_word(input logic [W-1:0] w, input int hold);
    logic [W-1:0]      exp_code;
    logic [DIGITS-1:0] exp_mask;
    logic [W-1:0]      held_code;
    logic [DIGITS-1:0] held_mask;
    exp_code = ref_code(w, exp_mask);
    wait_ready();
    in_valid = 1'b1;
    in_bcd   = w;
    tick();
    in_valid = 1'b0;
    in_bcd   = $urandom();
    for (int k = 1; k < DIGITS; k++) begin
      check($sformatf("busy_%0h_e%0d", w, k), 64'(busy), 64'd1);
      check($sformatf("nvalid_%0h_e%0d", w, k), 64'(out_valid), 64'd0);
      tick();
    end
    check($sformatf("busy_%0h_last", w), 64'(busy), 64'd1);
    tick();
    check($sformatf("valid_%0h", w), 64'(out_valid), 64'd1);
    check($sformatf("busy_off_%0h", w), 64'(busy), 64'd0);
    check($sformatf("code_%0h", w), 64'(out_code), 64'(exp_code));
    check($sformatf("mask_%0h", w), 64'(err_mask), 64'(exp_mask));
    check($sformatf("err_%0h", w), 64'(out_err), 64'(|exp_mask));
    held_code = out_code;
    held_mask = err_mask;
    for (int i = 0; i < hold; i++) begin
      in_valid = $urandom_range(0, 1);
      in_bcd   = $urandom();
      #1;
      check($sformatf("bp_ready_%0h", w), 64'(in_ready), 64'd0);
      tick();
      check($sformatf("bp_valid_%0h", w), 64'(out_valid), 64'd1);
      check($sformatf("bp_code_%0h", w), 64'(out_code), 64'(exp_code));
      check($sformatf("bp_mask_%0h", w), 64'(err_mask), 64'(exp_mask));
    end
    in_valid  = 1'b1;
    in_bcd    = $urandom();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check($sformatf("release_ready_%0h", w), 64'(in_ready), 64'd1);
    check($sformatf("release_nvalid_%0h", w), 64'(out_valid), 64'd0);
    check($sformatf("release_busy_%0h", w), 64'(busy), 64'd0);
    check($sformatf("keep_code_%0h", w), 64'(out_code), 64'(held_code));
    check($sformatf("keep_mask_%0h", w), 64'(err_mask), 64'(held_mask));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bcd    = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 64'(in_ready), 64'd1);
    check("idle_out_valid", 64'(out_valid), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_code", 64'(out_code), 64'd0);
    check("idle_mask", 64'(err_mask), 64'd0);

    run_word(16'h1234, 0);
    check("plan_1234", 64'(out_code), 64'h7654);
    run_word(16'h9805, 1);
    check("plan_9805", 64'(out_code), 64'hF80B);
    run_word(16'h0000, 0);
    check("plan_0000", 64'(out_code), 64'h0000);
    run_word(16'h12A4, 2);
    check("plan_12a4", 64'(out_code), 64'h7604);
    check("plan_12a4_mask", 64'(err_mask), 64'b0010);
    run_word(16'hFFFF, 0);
    check("plan_ffff_mask", 64'(err_mask), 64'b1111);
    run_word(16'h9999, 6);
    check("plan_9999", 64'(out_code), 64'hFFFF);

    // Reset in the second CONV cycle abandons the word.
    wait_ready();
    in_valid = 1'b1;
    in_bcd   = 16'h5678;
    tick();
    in_valid = 1'b0;
    check("mid_busy1", 64'(busy), 64'd1);
    tick();
    check("mid_busy2", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 64'(in_ready), 64'd0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("mid_idle_ready", 64'(in_ready), 64'd1);
    check("mid_idle_busy", 64'(busy), 64'd0);
    check("mid_idle_code", 64'(out_code), 64'd0);
    check("mid_idle_mask", 64'(err_mask), 64'd0);
    for (int i = 0; i < DIGITS + 2; i++) begin
      tick();
      check("mid_no_valid", 64'(out_valid), 64'd0);
    end
    run_word(16'h0009, 0);
    check("plan_0009", 64'(out_code), 64'h000F);

    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] w;
      w = W'($urandom());
      if (n % 3 != 0) begin
        for (int k = 0; k < DIGITS; k++) w[4*k +: 4] = 4'($urandom_range(0, 9));
      end
      run_word(w, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
